// File: rtl/readout_digit_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// readout_digit_sequencer_pkg
// Shared constants, FSM state type and helpers for the 4-digit readout
// sequencer and its binary-to-BCD engine.
// ---------------------------------------------------------------------------
package readout_digit_sequencer_pkg;

    localparam logic [3:0] BLANK_CODE = 4'hF;
    localparam int         NUM_DIGITS = 4;
    localparam int         BIN_W      = 14;
    localparam int         BCD_W      = 4 * NUM_DIGITS;
    localparam int         MAX_VALUE  = 9999;

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        PENDING
    } seq_state_e;

    // Replace most-significant zero digits with the blank code. The least
    // significant digit is always kept so a value of zero still shows "0".
    function automatic logic [BCD_W-1:0] blank_leading_zeros(input logic [BCD_W-1:0] digits);
        logic [BCD_W-1:0] result;
        logic             leading;
        result  = digits;
        leading = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            if (leading && (digits[i*4 +: 4] == 4'd0)) begin
                result[i*4 +: 4] = BLANK_CODE;
            end else begin
                leading = 1'b0;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/readout_digit_sequencer_if.sv
// ---------------------------------------------------------------------------
// readout_digit_sequencer_if
// Bundles the measurement input, VGA pixel coordinates and the glyph-steering
// outputs of the readout sequencer.
//   slave  : the sequencer (consumes VALUE/coords, drives status + decode)
//   master : the surrounding logic (measurement source + renderer bank)
// ---------------------------------------------------------------------------
interface readout_digit_sequencer_if;
    logic [13:0] VALUE;
    logic        VALUE_VALID;
    logic [11:0] VGA_horzCoord;
    logic [11:0] VGA_vertCoord;
    logic        BUSY;
    logic        OVER;
    logic        CELL_ACTIVE;
    logic [1:0]  CELL_IDX;
    logic [3:0]  DIGIT_CODE;
    logic [11:0] CELL_X;
    logic [11:0] CELL_Y;
    logic [11:0] HORZ_D;
    logic [11:0] VERT_D;

    modport slave (
        input  VALUE, VALUE_VALID, VGA_horzCoord, VGA_vertCoord,
        output BUSY, OVER, CELL_ACTIVE, CELL_IDX, DIGIT_CODE,
               CELL_X, CELL_Y, HORZ_D, VERT_D
    );

    modport master (
        output VALUE, VALUE_VALID, VGA_horzCoord, VGA_vertCoord,
        input  BUSY, OVER, CELL_ACTIVE, CELL_IDX, DIGIT_CODE,
               CELL_X, CELL_Y, HORZ_D, VERT_D
    );
endinterface

// File: rtl/readout_digit_sequencer_bcd_shift_add3.sv
// ---------------------------------------------------------------------------
// bcd_shift_add3
// Iterative binary-to-BCD converter (shift-add-3, one bit per cycle).
//   clk, rst : clock, asynchronous active-high reset
//   start    : load bin_in and begin a conversion
//   bin_in   : BIN_W-bit unsigned value (caller keeps it <= MAX_VALUE)
//   done     : one-cycle pulse, bcd_out valid while high
//   bcd_out  : 4 BCD nibbles, most significant digit in the top nibble
// start -> done is BIN_W+1 cycles.
// ---------------------------------------------------------------------------
module bcd_shift_add3
    import readout_digit_sequencer_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [BIN_W-1:0] bin_in,
    output logic             done,
    output logic [BCD_W-1:0] bcd_out
);

    logic [BCD_W-1:0] bcd_q, bcd_d, bcd_adj;
    logic [BIN_W-1:0] bin_q, bin_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             active_q, active_d;
    logic             done_q, done_d;

    // Pre-shift correction: any nibble of 5 or more would exceed 9 after
    // doubling, so bias it by 3 to carry into the next nibble.
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_adj
        assign bcd_adj[gi*4 +: 4] = (bcd_q[gi*4 +: 4] >= 4'd5) ?
                                    bcd_q[gi*4 +: 4] + 4'd3 : bcd_q[gi*4 +: 4];
    end

    always_comb begin
        bcd_d    = bcd_q;
        bin_d    = bin_q;
        cnt_d    = cnt_q;
        active_d = active_q;
        done_d   = 1'b0;
        if (start) begin
            bcd_d    = '0;
            bin_d    = bin_in;
            cnt_d    = 4'(BIN_W);
            active_d = 1'b1;
        end else if (active_q) begin
            bcd_d = {bcd_adj[BCD_W-2:0], bin_q[BIN_W-1]};
            bin_d = {bin_q[BIN_W-2:0], 1'b0};
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
                active_d = 1'b0;
                done_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcd_q    <= '0;
            bin_q    <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            bcd_q    <= bcd_d;
            bin_q    <= bin_d;
            cnt_q    <= cnt_d;
            active_q <= active_d;
            done_q   <= done_d;
        end
    end

    assign done    = done_q;
    assign bcd_out = bcd_q;

endmodule

// File: rtl/readout_digit_sequencer.sv
// ---------------------------------------------------------------------------
// readout_digit_sequencer
// Converts a binary measurement to 4 BCD digits, commits them to the display
// only at the frame-boundary pixel (COMMIT_LINE, X=0), and decodes the
// current pixel into cell index / digit code / cell origin one cycle later.
//   CLK_VGA : pixel clock          RESET : asynchronous active-high reset
//   bus     : readout_digit_sequencer_if.slave (VALUE, VALUE_VALID, coords in;
//             BUSY, OVER, CELL_*, DIGIT_CODE, HORZ_D, VERT_D out)
// Build option: define READOUT_LZB_EN to blank most-significant zero digits.
// ---------------------------------------------------------------------------
module readout_digit_sequencer
    import readout_digit_sequencer_pkg::*;
#(
    parameter int START_X     = 85,
    parameter int START_Y     = 150,
    parameter int CELL_W      = 20,
    parameter int CELL_H      = 40,
    parameter int PITCH       = 30,
    parameter int COMMIT_LINE = 1025
) (
    input logic                        CLK_VGA,
    input logic                        RESET,
    readout_digit_sequencer_if.slave   bus
);

    seq_state_e       state_q, state_d;
    logic             slot_full_q, slot_full_d;
    logic [BIN_W-1:0] slot_val_q, slot_val_d;
    logic             slot_sat_q, slot_sat_d;
    logic             conv_sat_q, conv_sat_d;
    logic [BCD_W-1:0] pend_digits_q, pend_digits_d;
    logic             pend_sat_q, pend_sat_d;
    logic [BCD_W-1:0] disp_digits_q, disp_digits_d;
    logic             disp_over_q, disp_over_d;

    logic             eng_start, eng_done;
    logic [BIN_W-1:0] eng_value;
    logic [BCD_W-1:0] eng_bcd, eng_bcd_fmt;
    logic             in_sat, commit_point;
    logic [BIN_W-1:0] in_clamped;

    assign in_sat       = (bus.VALUE > BIN_W'(MAX_VALUE));
    assign in_clamped   = in_sat ? BIN_W'(MAX_VALUE) : bus.VALUE;
    assign commit_point = (bus.VGA_vertCoord == 12'(COMMIT_LINE)) && (bus.VGA_horzCoord == 12'd0);

`ifdef READOUT_LZB_EN
    assign eng_bcd_fmt = blank_leading_zeros(eng_bcd);
`else
    assign eng_bcd_fmt = eng_bcd;
`endif

    bcd_shift_add3 u_bcd (
        .clk     (CLK_VGA),
        .rst     (RESET),
        .start   (eng_start),
        .bin_in  (eng_value),
        .done    (eng_done),
        .bcd_out (eng_bcd)
    );

    always_comb begin
        state_d       = state_q;
        slot_full_d   = slot_full_q;
        slot_val_d    = slot_val_q;
        slot_sat_d    = slot_sat_q;
        conv_sat_d    = conv_sat_q;
        pend_digits_d = pend_digits_q;
        pend_sat_d    = pend_sat_q;
        disp_digits_d = disp_digits_q;
        disp_over_d   = disp_over_q;
        eng_start     = 1'b0;
        eng_value     = '0;
        unique case (state_q)
            IDLE: begin
                // A held value takes priority; a fresh strobe arriving in the
                // same cycle falls through to the slot below.
                if (slot_full_q) begin
                    eng_start   = 1'b1;
                    eng_value   = slot_val_q;
                    conv_sat_d  = slot_sat_q;
                    slot_full_d = 1'b0;
                    state_d     = CONVERT;
                end else if (bus.VALUE_VALID) begin
                    eng_start  = 1'b1;
                    eng_value  = in_clamped;
                    conv_sat_d = in_sat;
                    state_d    = CONVERT;
                end
            end
            CONVERT: begin
                if (eng_done) begin
                    pend_digits_d = eng_bcd_fmt;
                    pend_sat_d    = conv_sat_q;
                    state_d       = PENDING;
                end
            end
            PENDING: begin
                if (commit_point) begin
                    disp_digits_d = pend_digits_q;
                    disp_over_d   = pend_sat_q;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // One-deep holding slot, latest strobe wins.
        if (bus.VALUE_VALID && ((state_q != IDLE) || slot_full_q)) begin
            slot_full_d = 1'b1;
            slot_val_d  = in_clamped;
            slot_sat_d  = in_sat;
        end
    end

    always_ff @(posedge CLK_VGA or posedge RESET) begin
        if (RESET) begin
            state_q       <= IDLE;
            slot_full_q   <= 1'b0;
            slot_val_q    <= '0;
            slot_sat_q    <= 1'b0;
            conv_sat_q    <= 1'b0;
            pend_digits_q <= {NUM_DIGITS{BLANK_CODE}};
            pend_sat_q    <= 1'b0;
            disp_digits_q <= {NUM_DIGITS{BLANK_CODE}};
            disp_over_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            slot_full_q   <= slot_full_d;
            slot_val_q    <= slot_val_d;
            slot_sat_q    <= slot_sat_d;
            conv_sat_q    <= conv_sat_d;
            pend_digits_q <= pend_digits_d;
            pend_sat_q    <= pend_sat_d;
            disp_digits_q <= disp_digits_d;
            disp_over_q   <= disp_over_d;
        end
    end

    // ---------------- pixel decode ----------------
    logic [NUM_DIGITS-1:0] cell_hit;
    logic [3:0]            cell_code [NUM_DIGITS];
    logic [11:0]           cell_org  [NUM_DIGITS];
    logic                  row_hit;

    assign row_hit = (bus.VGA_vertCoord >= 12'(START_Y)) &&
                     (bus.VGA_vertCoord <  12'(START_Y + CELL_H));

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_cell
        localparam logic [11:0] ORG_X = 12'(START_X + gi * PITCH);
        assign cell_org[gi]  = ORG_X;
        // Cell 0 is the leftmost, i.e. the most significant nibble.
        assign cell_code[gi] = disp_digits_q[(NUM_DIGITS-1-gi)*4 +: 4];
        assign cell_hit[gi]  = row_hit && (bus.VGA_horzCoord >= ORG_X) &&
                               (bus.VGA_horzCoord < ORG_X + 12'(CELL_W));
    end

    logic        cell_active_q, cell_active_d;
    logic [1:0]  cell_idx_q, cell_idx_d;
    logic [3:0]  digit_code_q, digit_code_d;
    logic [11:0] cell_x_q, cell_x_d;
    logic [11:0] horz_q, vert_q;

    always_comb begin
        cell_active_d = 1'b0;
        cell_idx_d    = 2'd0;
        digit_code_d  = BLANK_CODE;
        cell_x_d      = 12'(START_X);
        // Cells never overlap (PITCH > CELL_W), so at most one hit is set.
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            if (cell_hit[k]) begin
                cell_active_d = 1'b1;
                cell_idx_d    = 2'(k);
                digit_code_d  = cell_code[k];
                cell_x_d      = cell_org[k];
            end
        end
    end

    always_ff @(posedge CLK_VGA or posedge RESET) begin
        if (RESET) begin
            cell_active_q <= 1'b0;
            cell_idx_q    <= 2'd0;
            digit_code_q  <= BLANK_CODE;
            cell_x_q      <= 12'(START_X);
            horz_q        <= '0;
            vert_q        <= '0;
        end else begin
            cell_active_q <= cell_active_d;
            cell_idx_q    <= cell_idx_d;
            digit_code_q  <= digit_code_d;
            cell_x_q      <= cell_x_d;
            horz_q        <= bus.VGA_horzCoord;
            vert_q        <= bus.VGA_vertCoord;
        end
    end

    // A queued value keeps BUSY high across the single IDLE cycle between
    // a commit and the start of the next conversion.
    assign bus.BUSY        = (state_q != IDLE) || slot_full_q;
    assign bus.OVER        = disp_over_q;
    assign bus.CELL_ACTIVE = cell_active_q;
    assign bus.CELL_IDX    = cell_idx_q;
    assign bus.DIGIT_CODE  = digit_code_q;
    assign bus.CELL_X      = cell_x_q;
    assign bus.CELL_Y      = 12'(START_Y);
    assign bus.HORZ_D      = horz_q;
    assign bus.VERT_D      = vert_q;

endmodule

// File: doc/readout_digit_sequencer.md
# readout_digit_sequencer

Sequences the on-screen 4-digit numeric readout for the oscilloscope display. Accepts a binary measurement value, converts it to BCD with a multi-cycle shift-add-3 engine, and commits the new digits only at a frame-boundary scanline so the readout never tears. It then steers the per-digit glyph renderers by decoding the current pixel into a cell index, digit code and cell origin. It sits between the measurement logic and the glyph renderer bank, in the VGA pixel clock domain.

## Interface
Parameters:
- START_X, 85, X-coord of left edge of digit cell 0
- START_Y, 150, Y-coord of top edge of all cells
- CELL_W, 20, glyph width in pixels
- CELL_H, 40, glyph height in pixels
- PITCH, 30, horizontal distance between cell origins (must be ≥ CELL_W+1)
- COMMIT_LINE, 1025, scanline on which pending digits are committed (outside active area)

Ports (one clock; reset is asynchronous and active-high):
- CLK_VGA  in  1  VGA pixel clock
- RESET  in  1  asynchronous active-high reset
- VALUE  in  14  binary measurement, unsigned
- VALUE_VALID  in  1  one-cycle strobe, VALUE sampled when high
- VGA_horzCoord  in  12  current pixel X
- VGA_vertCoord  in  12  current pixel Y
- BUSY  out  1  conversion or commit pending
- OVER  out  1  committed value was saturated (VALUE > 9999)
- CELL_ACTIVE  out  1  delayed pixel lies inside one of the 4 cell boxes
- CELL_IDX  out  2  cell index, 0 = leftmost (most significant)
- DIGIT_CODE  out  4  BCD digit for that cell; 4'hF = blank
- CELL_X  out  12  origin X of that cell (START_X + CELL_IDX*PITCH)
- CELL_Y  out  12  origin Y (START_Y)
- HORZ_D  out  12  VGA_horzCoord delayed 1 cycle
- VERT_D  out  12  VGA_vertCoord delayed 1 cycle

## Operation
- FSM states: IDLE, CONVERT, PENDING.
- IDLE: on VALUE_VALID, load min(VALUE, 9999) into shift register, record saturation flag, clear BCD accumulator, enter CONVERT.
- CONVERT: 14 iterations, one per cycle: each BCD nibble ≥5 gets +3, then shift left by 1 bit across BCD:binary. After the 14th, latch 4 nibbles into pending register, enter PENDING.
- PENDING: when VGA_vertCoord == COMMIT_LINE and VGA_horzCoord == 0, copy pending digits and saturation flag into display registers, drive OVER, return to IDLE.
- VALUE_VALID while not IDLE: value and flag captured into a one-deep holding slot (latest wins). On return to IDLE, if slot full, start CONVERT next cycle from slot and clear it.
- Pixel decode (registered): for k in 0..3, cell k is hit when START_X+k*PITCH ≤ X < START_X+k*PITCH+CELL_W and START_Y ≤ Y < START_Y+CELL_H. No hit: CELL_ACTIVE=0, CELL_IDX=0, DIGIT_CODE=4'hF, CELL_X=START_X.
- All cell-origin arithmetic done in 12 bits; parameters guarantee no overflow.

## Timing
- Reset values: BUSY=0, OVER=0, CELL_ACTIVE=0, CELL_IDX=0, DIGIT_CODE=4'hF, CELL_X=START_X, CELL_Y=START_Y, HORZ_D=0, VERT_D=0; display digits all blank; holding slot empty; FSM IDLE.
- BUSY high from the cycle after VALUE_VALID until the cycle after commit.
- Strobe-to-PENDING latency: 15 cycles.
- Display outputs change only on the cycle after the commit point; commit is never mid-frame.
- Pixel decode latency: 1 cycle; HORZ_D/VERT_D aligned with decode outputs.
- Reset mid-conversion: all state discarded, display blanked, no commit.
- VALUE_VALID on the commit cycle: goes to holding slot, converted next.

## Configuration
- READOUT_LZB_EN defined: leading-zero blanking, most-significant zero digits shown as 4'hF, least-significant digit always shown (value 0 -> blank,blank,blank,0).
- Undefined: all 4 digits always shown, zeros included (value 42 -> 0,0,4,2).

## Structure
- Shared package: BLANK_CODE = 4'hF, NUM_DIGITS = 4, BIN_W = 14, MAX_VALUE = 9999, FSM state enum.
- One sub-module: bcd_shift_add3, the iterative binary-to-BCD engine (start/done handshake), instantiated once.

## Test plan
- Reset with no input -> all cells blank, OVER=0, BUSY=0, CELL_ACTIVE=1 at (X=85,Y=150) one cycle later.
- VALUE=1234, commit line reached -> digits 1,2,3,4; pixel (115,160) -> CELL_IDX=1, DIGIT_CODE=2, CELL_X=115.
- VALUE=12000 -> digits 9,9,9,9, OVER=1 after commit.
- VALUE=42 then VALUE=7 within 5 cycles -> 42 committed first frame, 7 on next commit, 42 never skipped mid-frame.
- VALUE=42 with READOUT_LZB_EN -> F,F,4,2; without -> 0,0,4,2.
- RESET asserted 8 cycles into CONVERT -> BUSY=0 immediately, digits blank, nothing committed at COMMIT_LINE.
